cdb_arbiter: RTL and testbench

CDB_ARBITER -- requirements
Module: cdb_arbiter

---
 rtl/cdb_arbiter_if.sv | 29 ++
 rtl/cdb_arbiter.sv | 119 +++++++++++
 tb/tb_cdb_arbiter.sv | 152 +++++++++++++++
 3 files changed

// File: rtl/cdb_arbiter_if.sv
// rtl/cdb_arbiter_if.sv - result-source and CDB broadcast signals for cdb_arbiter.
// master = producers/consumers around the arbiter, slave = the arbiter itself.
interface cdb_arbiter_if;
  logic        flush;
  logic        alu_valid;
  logic [31:0] alu_pc;
  logic [31:0] alu_data;
  logic [31:0] alu_jpc;
  logic        alu_ready;
  logic        slb_valid;
  logic [31:0] slb_pc;
  logic [31:0] slb_data;
  logic        slb_ready;
  logic        cdb_valid;
  logic        cdb_src;
  logic [31:0] cdb_pc;
  logic [31:0] cdb_data;
  logic [31:0] cdb_jpc;

  modport master (
    output flush, alu_valid, alu_pc, alu_data, alu_jpc, slb_valid, slb_pc, slb_data,
    input  alu_ready, slb_ready, cdb_valid, cdb_src, cdb_pc, cdb_data, cdb_jpc
  );

  modport slave (
    input  flush, alu_valid, alu_pc, alu_data, alu_jpc, slb_valid, slb_pc, slb_data,
    output alu_ready, slb_ready, cdb_valid, cdb_src, cdb_pc, cdb_data, cdb_jpc
  );
endinterface

// File: rtl/cdb_arbiter.sv
// rtl/cdb_arbiter.sv - two-source queued CDB arbiter (ALU, SLB), one broadcast per cycle.
// Optional CDB_ALU_PRIORITY_EN: ties always go to ALU instead of round-robin.
module cdb_arbiter #(
  parameter int FIFO_DEPTH = 4,
  parameter int PTR_W      = 2
) (
  input logic             clk,
  input logic             rst,
  cdb_arbiter_if.slave    bus
);
  localparam logic [PTR_W:0] FULL_CNT = (PTR_W + 1)'(FIFO_DEPTH);

  logic [31:0] alu_pc_mem   [FIFO_DEPTH];
  logic [31:0] alu_data_mem [FIFO_DEPTH];
  logic [31:0] alu_jpc_mem  [FIFO_DEPTH];
  logic [31:0] slb_pc_mem   [FIFO_DEPTH];
  logic [31:0] slb_data_mem [FIFO_DEPTH];

  logic [PTR_W-1:0] alu_head_q, alu_tail_q, slb_head_q, slb_tail_q;
  logic [PTR_W:0]   alu_cnt_q, alu_cnt_d, slb_cnt_q, slb_cnt_d;
  logic             cdb_valid_q, cdb_src_q;
  logic [31:0]      cdb_pc_q, cdb_data_q, cdb_jpc_q;

  logic alu_ready, slb_ready, alu_push, slb_push, alu_ne, slb_ne;
  logic pick_slb, alu_pop, slb_pop;

  assign alu_ready = (alu_cnt_q != FULL_CNT) && !bus.flush;
  assign slb_ready = (slb_cnt_q != FULL_CNT) && !bus.flush;
  assign alu_push  = bus.alu_valid && alu_ready;
  assign slb_push  = bus.slb_valid && slb_ready;
  assign alu_ne    = alu_cnt_q != '0;
  assign slb_ne    = slb_cnt_q != '0;

`ifdef CDB_ALU_PRIORITY_EN
  assign pick_slb = slb_ne && !alu_ne;
`else
  // last_grant_q = 1 means SLB won last, so a tie now goes to ALU.
  logic last_grant_q;
  assign pick_slb = slb_ne && (!alu_ne || !last_grant_q);
`endif

  assign alu_pop   = !bus.flush && alu_ne && !pick_slb;
  assign slb_pop   = !bus.flush && pick_slb;
  assign alu_cnt_d = alu_cnt_q + (PTR_W + 1)'(alu_push) - (PTR_W + 1)'(alu_pop);
  assign slb_cnt_d = slb_cnt_q + (PTR_W + 1)'(slb_push) - (PTR_W + 1)'(slb_pop);

  // Queue storage carries no reset; pointers and counts define validity.
  always_ff @(posedge clk) begin
    if (alu_push) begin
      alu_pc_mem[alu_tail_q]   <= bus.alu_pc;
      alu_data_mem[alu_tail_q] <= bus.alu_data;
      alu_jpc_mem[alu_tail_q]  <= bus.alu_jpc;
    end
    if (slb_push) begin
      slb_pc_mem[slb_tail_q]   <= bus.slb_pc;
      slb_data_mem[slb_tail_q] <= bus.slb_data;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      alu_head_q  <= '0;
      alu_tail_q  <= '0;
      alu_cnt_q   <= '0;
      slb_head_q  <= '0;
      slb_tail_q  <= '0;
      slb_cnt_q   <= '0;
      cdb_valid_q <= 1'b0;
      cdb_src_q   <= 1'b0;
      cdb_pc_q    <= '0;
      cdb_data_q  <= '0;
      cdb_jpc_q   <= '0;
`ifndef CDB_ALU_PRIORITY_EN
      last_grant_q <= 1'b1;
`endif
    end else if (bus.flush) begin
      alu_head_q  <= '0;
      alu_tail_q  <= '0;
      alu_cnt_q   <= '0;
      slb_head_q  <= '0;
      slb_tail_q  <= '0;
      slb_cnt_q   <= '0;
      cdb_valid_q <= 1'b0;
`ifndef CDB_ALU_PRIORITY_EN
      last_grant_q <= 1'b1;
`endif
    end else begin
      if (alu_push) alu_tail_q <= alu_tail_q + 1'b1;
      if (slb_push) slb_tail_q <= slb_tail_q + 1'b1;
      if (alu_pop)  alu_head_q <= alu_head_q + 1'b1;
      if (slb_pop)  slb_head_q <= slb_head_q + 1'b1;
      alu_cnt_q   <= alu_cnt_d;
      slb_cnt_q   <= slb_cnt_d;
      cdb_valid_q <= alu_pop || slb_pop;
      if (alu_pop) begin
        cdb_src_q  <= 1'b0;
        cdb_pc_q   <= alu_pc_mem[alu_head_q];
        cdb_data_q <= alu_data_mem[alu_head_q];
        cdb_jpc_q  <= alu_jpc_mem[alu_head_q];
      end else if (slb_pop) begin
        cdb_src_q  <= 1'b1;
        cdb_pc_q   <= slb_pc_mem[slb_head_q];
        cdb_data_q <= slb_data_mem[slb_head_q];
        cdb_jpc_q  <= slb_pc_mem[slb_head_q] + 32'd4;
      end
`ifndef CDB_ALU_PRIORITY_EN
      if (alu_pop || slb_pop) last_grant_q <= slb_pop;
`endif
    end
  end

  assign bus.alu_ready = alu_ready;
  assign bus.slb_ready = slb_ready;
  assign bus.cdb_valid = cdb_valid_q;
  assign bus.cdb_src   = cdb_src_q;
  assign bus.cdb_pc    = cdb_pc_q;
  assign bus.cdb_data  = cdb_data_q;
  assign bus.cdb_jpc   = cdb_jpc_q;
endmodule

// File: tb/tb_cdb_arbiter.sv
// tb/tb_cdb_arbiter.sv - directed vector table plus queue-model scoreboard for cdb_arbiter.
module tb_cdb_arbiter;
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  cdb_arbiter_if bus ();
  cdb_arbiter #(.FIFO_DEPTH(4), .PTR_W(2)) dut (.clk(clk), .rst(rst), .bus(bus));

  int n_chk  = 0;
  int n_pass = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", nm, act, exp);
  endtask

  typedef struct {
    logic        fl;
    logic        av;
    logic [31:0] apc, adat, ajpc;
    logic        sv;
    logic [31:0] spc, sdat;
    logic        ev, es;
    logic [31:0] epc, edat, ejpc;
    logic        ear, esr;
  } vec_t;

  typedef struct {
    logic [31:0] pc, data, jpc;
  } ent_t;

  vec_t tv[14];
  ent_t aq[$];
  ent_t sq[$];

  task automatic drive(input logic fl, input logic av, input logic [31:0] apc, input logic [31:0] adat,
                       input logic [31:0] ajpc, input logic sv, input logic [31:0] spc, input logic [31:0] sdat);
    bus.flush     = fl;
    bus.alu_valid = av;
    bus.alu_pc    = apc;
    bus.alu_data  = adat;
    bus.alu_jpc   = ajpc;
    bus.slb_valid = sv;
    bus.slb_pc    = spc;
    bus.slb_data  = sdat;
  endtask

  task automatic chk_cdb(input string tag, input logic ev, input logic es, input logic [31:0] epc,
                         input logic [31:0] edat, input logic [31:0] ejpc);
    chk({tag, " cdb_valid"}, 32'(bus.cdb_valid), 32'(ev));
    chk({tag, " cdb_src"},   32'(bus.cdb_src),   32'(es));
    chk({tag, " cdb_pc"},    bus.cdb_pc,   epc);
    chk({tag, " cdb_data"},  bus.cdb_data, edat);
    chk({tag, " cdb_jpc"},   bus.cdb_jpc,  ejpc);
  endtask

  initial begin
    logic        lg, ev, es, fl, apend, spend, ear, esr, ane, sne, pick_s;
    logic [31:0] hpc, hdat, hjpc;
    ent_t        a_in, s_in, e;

    tv[0]  = '{0, 1, 32'h100, 32'h5,  32'h104, 0, 32'h0,   32'h0,  0, 0, 32'h0,   32'h0,  32'h0,   1, 1};
    tv[1]  = '{0, 0, 32'h0,   32'h0,  32'h0,   0, 32'h0,   32'h0,  1, 0, 32'h100, 32'h5,  32'h104, 1, 1};
    tv[2]  = '{0, 0, 32'h0,   32'h0,  32'h0,   0, 32'h0,   32'h0,  0, 0, 32'h100, 32'h5,  32'h104, 1, 1};
    tv[3]  = '{1, 0, 32'h0,   32'h0,  32'h0,   0, 32'h0,   32'h0,  0, 0, 32'h100, 32'h5,  32'h104, 0, 0};
    tv[4]  = '{0, 1, 32'h200, 32'hA1, 32'h204, 1, 32'h300, 32'hB1, 0, 0, 32'h100, 32'h5,  32'h104, 1, 1};
    tv[5]  = '{0, 1, 32'h210, 32'hA2, 32'h214, 1, 32'h310, 32'hB2, 1, 0, 32'h200, 32'hA1, 32'h204, 1, 1};
    tv[6]  = '{0, 1, 32'h220, 32'hA3, 32'h224, 1, 32'h320, 32'hB3, 1, 1, 32'h300, 32'hB1, 32'h304, 1, 1};
    tv[7]  = '{0, 0, 32'h0,   32'h0,  32'h0,   0, 32'h0,   32'h0,  1, 0, 32'h210, 32'hA2, 32'h214, 1, 1};
    tv[8]  = '{0, 0, 32'h0,   32'h0,  32'h0,   0, 32'h0,   32'h0,  1, 1, 32'h310, 32'hB2, 32'h314, 1, 1};
    tv[9]  = '{0, 0, 32'h0,   32'h0,  32'h0,   0, 32'h0,   32'h0,  1, 0, 32'h220, 32'hA3, 32'h224, 1, 1};
    tv[10] = '{0, 0, 32'h0,   32'h0,  32'h0,   0, 32'h0,   32'h0,  1, 1, 32'h320, 32'hB3, 32'h324, 1, 1};
    tv[11] = '{0, 0, 32'h0,   32'h0,  32'h0,   0, 32'h0,   32'h0,  0, 1, 32'h320, 32'hB3, 32'h324, 1, 1};
    tv[12] = '{0, 0, 32'h0,   32'h0,  32'h0,   1, 32'hFFFFFFFC, 32'h77, 0, 1, 32'h320, 32'hB3, 32'h324, 1, 1};
    tv[13] = '{0, 0, 32'h0,   32'h0,  32'h0,   0, 32'h0,   32'h0,  1, 1, 32'hFFFFFFFC, 32'h77, 32'h0, 1, 1};

    drive(0, 0, 0, 0, 0, 0, 0, 0);
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    #1;
    chk_cdb("reset", 0, 0, 32'h0, 32'h0, 32'h0);
    chk("reset alu_ready", 32'(bus.alu_ready), 32'd1);
    chk("reset slb_ready", 32'(bus.slb_ready), 32'd1);

    for (int i = 0; i < 14; i++) begin
      @(negedge clk);
      drive(tv[i].fl, tv[i].av, tv[i].apc, tv[i].adat, tv[i].ajpc, tv[i].sv, tv[i].spc, tv[i].sdat);
      @(posedge clk);
      #1;
      chk_cdb($sformatf("vec%0d", i), tv[i].ev, tv[i].es, tv[i].epc, tv[i].edat, tv[i].ejpc);
      chk($sformatf("vec%0d alu_ready", i), 32'(bus.alu_ready), 32'(tv[i].ear));
      chk($sformatf("vec%0d slb_ready", i), 32'(bus.slb_ready), 32'(tv[i].esr));
    end

    // Scoreboard phase: both sources push faster than one pop per cycle, so queues
    // fill and exercise held requests, full-with-pop, and random flushes.
    hpc = 32'hFFFFFFFC; hdat = 32'h77; hjpc = 32'h0; es = 1'b1;
    lg = 1'b1; apend = 1'b0; spend = 1'b0;
    a_in = '{32'h0, 32'h0, 32'h0};
    s_in = '{32'h0, 32'h0, 32'h0};
    @(negedge clk);
    drive(1, 0, 0, 0, 0, 0, 0, 0);
    @(posedge clk);
    for (int c = 0; c < 120; c++) begin
      @(negedge clk);
      fl = (c > 10) && ($urandom_range(0, 19) == 0);
      if (!apend && $urandom_range(0, 3) != 0) begin
        a_in.pc = $urandom; a_in.data = $urandom; a_in.jpc = $urandom; apend = 1'b1;
      end
      if (!spend && $urandom_range(0, 3) != 0) begin
        s_in.pc = ($urandom_range(0, 7) == 0) ? 32'hFFFFFFFC : $urandom;
        s_in.data = $urandom; s_in.jpc = s_in.pc + 32'd4; spend = 1'b1;
      end
      drive(fl, apend, a_in.pc, a_in.data, a_in.jpc, spend, s_in.pc, s_in.data);
      #1;
      ear = (aq.size() != 4) && !fl;
      esr = (sq.size() != 4) && !fl;
      chk($sformatf("sb%0d alu_ready", c), 32'(bus.alu_ready), 32'(ear));
      chk($sformatf("sb%0d slb_ready", c), 32'(bus.slb_ready), 32'(esr));
      if (fl) begin
        aq.delete(); sq.delete();
        lg = 1'b1; ev = 1'b0; apend = 1'b0; spend = 1'b0;
      end else begin
        ane = aq.size() > 0;
        sne = sq.size() > 0;
`ifdef CDB_ALU_PRIORITY_EN
        pick_s = sne && !ane;
`else
        pick_s = sne && (!ane || !lg);
`endif
        ev = ane || sne;
        if (ev) begin
          if (pick_s) e = sq.pop_front();
          else        e = aq.pop_front();
          es = pick_s; lg = pick_s;
          hpc = e.pc; hdat = e.data; hjpc = e.jpc;
        end
        if (apend && ear) begin aq.push_back(a_in); apend = 1'b0; end
        if (spend && esr) begin sq.push_back(s_in); spend = 1'b0; end
      end
      @(posedge clk);
      #1;
      chk_cdb($sformatf("sb%0d", c), ev, es, hpc, hdat, hjpc);
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
